ddr_rw_sched: RTL

Read/write mode scheduler for the 1W1R DDR user-interface datapath. Decides when the shared app port serves the read address FIFO and when it serves the write address/data FIFOs. It uses depth hysteresis and a starvation limit, drains in-flight commands before a switch, inserts a programmable bus-turnaround gap, and keeps two-beat write bursts intact. It sits between the address/data FIFOs and the command-issue datapath, and replaces ad-hoc sample-timer mode switching.

---
 rtl/ddr_rw_sched.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ddr_rw_sched.sv
// ddr_rw_sched: arbitrates the shared DDR app port between the read address
// FIFO and the write address/data FIFOs. Uses write-depth hysteresis plus
// per-window starvation limits. Drains the in-flight command and idles for a
// turnaround gap on every mode change. Two-beat write bursts are never split.
module ddr_rw_sched #(
    parameter int WDEPTH_W    = 9,
    parameter int SWH         = 384,
    parameter int SWL         = 128,
    parameter int TA_CYCLES   = 3,
    parameter int MAX_RD_CMDS = 64,
    parameter int MAX_WR_CMDS = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                raddr_fifo_empty,
    input  logic                waddr_fifo_empty,
    input  logic [WDEPTH_W-1:0] wdata_fifo_rdepth,
    input  logic                app_rdy,
    input  logic                app_wdf_rdy,
    input  logic                cmd_accept,
    input  logic                issue_busy,
    output logic                rd_grant,
    output logic                wr_grant,
    output logic                wr_phase,
    output logic                wr_mode,
    output logic [2:0]          sched_state,
    output logic [15:0]         switch_cnt
);

    typedef enum logic [2:0] {
        ST_RD       = 3'd0,
        ST_RD_DRAIN = 3'd1,
        ST_TA_R2W   = 3'd2,
        ST_WR       = 3'd3,
        ST_WR_DRAIN = 3'd4,
        ST_TA_W2R   = 3'd5
    } state_t;

    // Thresholds sized to the depth input so every compare is width-matched
    localparam logic [WDEPTH_W-1:0] SWH_D     = WDEPTH_W'(SWH);
    localparam logic [WDEPTH_W-1:0] SWL_D     = WDEPTH_W'(SWL);
    localparam logic [WDEPTH_W-1:0] DEPTH_ONE = WDEPTH_W'(1);
    localparam logic [WDEPTH_W-1:0] DEPTH_TWO = WDEPTH_W'(2);
    localparam logic [7:0]          RD_LIMIT  = 8'(MAX_RD_CMDS);
    localparam logic [7:0]          WR_LIMIT  = 8'(MAX_WR_CMDS);
    localparam logic [3:0]          TA_LAST   = 4'(TA_CYCLES - 1);

    state_t      state_reg;
    logic        wr_mode_reg;
    logic        wr_phase_reg;
    logic [15:0] switch_cnt_reg;
    logic [15:0] switch_cnt_next;
    logic [7:0]  rd_cnt_reg;
    logic [7:0]  wr_cnt_reg;
    logic [3:0]  ta_cnt_reg;

    logic wr_ok;
    logic rd_ok;
    logic sw_r2w;
    logic sw_w2r;
    logic ta_entry;

    // A first beat needs an address and both beats of data; a second beat only its own data
    assign wr_ok = wr_phase_reg ? (wdata_fifo_rdepth >= DEPTH_ONE)
                                : (!waddr_fifo_empty && (wdata_fifo_rdepth >= DEPTH_TWO));
    assign rd_ok = !raddr_fifo_empty;

    // Hysteresis and starvation terms collapse into one switch request per direction
    assign sw_r2w = wr_ok && ((wdata_fifo_rdepth >= SWH_D) || raddr_fifo_empty ||
                              (rd_cnt_reg == RD_LIMIT));
    assign sw_w2r = !wr_phase_reg && rd_ok &&
                    ((wdata_fifo_rdepth <= SWL_D) || !wr_ok || (wr_cnt_reg == WR_LIMIT));

    // A drain state leaves once no fetched command is left waiting
    assign ta_entry = ((state_reg == ST_RD_DRAIN) || (state_reg == ST_WR_DRAIN)) && !issue_busy;

    // Grants are combinational so a pop can happen in the same cycle app_rdy rises;
    // held low during reset so nothing is popped before the scheduler is live
    assign rd_grant = rst_n && (state_reg == ST_RD) && app_rdy && rd_ok && !sw_r2w;
    assign wr_grant = rst_n && (state_reg == ST_WR) && app_rdy && app_wdf_rdy && wr_ok && !sw_w2r;

    // Switch counter advances on each turnaround entry and sticks at all-ones
    always_comb begin
        switch_cnt_next = switch_cnt_reg;
        if (ta_entry && (switch_cnt_reg != 16'hFFFF)) begin
            switch_cnt_next = switch_cnt_reg + 16'd1;
        end
    end

    // Scheduler FSM with its registered mode, burst phase and window counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_RD;
            wr_mode_reg    <= 1'b0;
            wr_phase_reg   <= 1'b0;
            switch_cnt_reg <= 16'd0;
            rd_cnt_reg     <= 8'd0;
            wr_cnt_reg     <= 8'd0;
            ta_cnt_reg     <= 4'd0;
        end else begin
            switch_cnt_reg <= switch_cnt_next;
            if (wr_grant) begin
                wr_phase_reg <= !wr_phase_reg;
            end
            case (state_reg)
                ST_RD: begin
                    if (cmd_accept && (rd_cnt_reg != RD_LIMIT)) begin
                        rd_cnt_reg <= rd_cnt_reg + 8'd1;
                    end
                    if (sw_r2w) begin
                        state_reg <= ST_RD_DRAIN;
                    end
                end
                ST_RD_DRAIN: begin
                    if (!issue_busy) begin
                        state_reg   <= ST_TA_R2W;
                        wr_mode_reg <= 1'b1;
                        ta_cnt_reg  <= 4'd0;
                    end
                end
                ST_TA_R2W: begin
                    if (ta_cnt_reg == TA_LAST) begin
                        state_reg  <= ST_WR;
                        wr_cnt_reg <= 8'd0;
                    end else begin
                        ta_cnt_reg <= ta_cnt_reg + 4'd1;
                    end
                end
                ST_WR: begin
                    if (cmd_accept && (wr_cnt_reg != WR_LIMIT)) begin
                        wr_cnt_reg <= wr_cnt_reg + 8'd1;
                    end
                    if (sw_w2r) begin
                        state_reg <= ST_WR_DRAIN;
                    end
                end
                ST_WR_DRAIN: begin
                    if (!issue_busy) begin
                        state_reg   <= ST_TA_W2R;
                        wr_mode_reg <= 1'b0;
                        ta_cnt_reg  <= 4'd0;
                    end
                end
                ST_TA_W2R: begin
                    if (ta_cnt_reg == TA_LAST) begin
                        state_reg  <= ST_RD;
                        rd_cnt_reg <= 8'd0;
                    end else begin
                        ta_cnt_reg <= ta_cnt_reg + 4'd1;
                    end
                end
                default: begin
                    // Unused encodings recover straight into read mode
                    state_reg   <= ST_RD;
                    wr_mode_reg <= 1'b0;
                    rd_cnt_reg  <= 8'd0;
                end
            endcase
        end
    end

    assign wr_phase    = wr_phase_reg;
    assign wr_mode     = wr_mode_reg;
    assign sched_state = state_reg;
    assign switch_cnt  = switch_cnt_reg;

endmodule
